// File: rtl/divider_rs_core_pkg.sv
// Shared definitions for the repetitive-subtraction divider: state encodings,
// state bit positions and the default operand width.
package divider_rs_core_pkg;

   localparam int DIV_WIDTH = 4;

   // Bit positions of the one-hot state inside {Qd,Qc,Qi}
   localparam int S_QI_IDX = 0;
   localparam int S_QC_IDX = 1;
   localparam int S_QD_IDX = 2;

   typedef enum logic [2:0] {
      QI = 3'b001,   // idle, waiting for Start
      QC = 3'b010,   // subtracting
      QD = 3'b100    // result valid, waiting for Ack
   } state_t;

endpackage

// File: rtl/divider_rs_core.sv
// Start/Ack/Done divider responder. Divides by repetitive subtraction:
// one subtract per clock while the remainder is still >= the divisor.
// A zero divisor bypasses the compute state and flags DivZero.
module divider_rs_core
   import divider_rs_core_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Ack,
   input  logic [WIDTH-1:0] Xin,
   input  logic [WIDTH-1:0] Yin,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             Done,
   output logic             DivZero,
   output logic             Qi,
   output logic             Qc,
   output logic             Qd
);

   state_t           r_state;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_y;
   logic             r_divz;
   logic             w_ge;

   // Unsigned compare guards the subtraction, so it can never underflow
   assign w_ge = (r_rem >= r_y);

   // State register plus datapath; non-one-hot codes fall back to QI
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= QI;
         r_quot  <= '0;
         r_rem   <= '0;
         r_y     <= '0;
         r_divz  <= 1'b0;
      end else begin
         case (r_state)
            QI: begin
               if (Start) begin
                  r_rem <= Xin;
                  if (Yin != '0) begin
                     r_y     <= Yin;
                     r_quot  <= '0;
                     r_divz  <= 1'b0;
                     r_state <= QC;
                  end else begin
                     // Divide by zero: report saturated quotient immediately
                     r_quot  <= '1;
                     r_divz  <= 1'b1;
                     r_state <= QD;
                  end
               end
            end
            QC: begin
               if (w_ge) begin
                  r_rem  <= r_rem - r_y;
                  r_quot <= r_quot + 1'b1;
               end else begin
                  r_state <= QD;
               end
            end
            QD: begin
               // Ack has priority; a still-high Start restarts from QI next edge
               if (Ack) r_state <= QI;
            end
            default: r_state <= QI;
         endcase
      end
   end

   assign Quotient  = r_quot;
   assign Remainder = r_rem;
   assign DivZero   = r_divz;
   assign Qi        = r_state[S_QI_IDX];
   assign Qc        = r_state[S_QC_IDX];
   assign Qd        = r_state[S_QD_IDX];
   assign Done      = r_state[S_QD_IDX];

endmodule
